uart_cmd_decoder: RTL and testbench

//  Parametrised successor of the single-letter UART command decoder. It takes the byte stream

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/bcd_ascii_fmt.sv | 21 ++
 rtl/uart_cmd_decoder.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_pkg
// Brief   : Shared types and constants for the UART command decoder.
// Revision: 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam int         MAX_CMD     = 8;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] i_nib);
        return (i_nib <= 4'd9) ? (ASCII_ZERO + {4'd0, i_nib}) : ASCII_QMARK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_ascii_fmt.sv
`default_nettype none
// ============================================================================
// Module  : bcd_ascii_fmt
// Brief   : Combinational BCD digit to ASCII mapper; non-decimal nibbles show '?'.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_ascii_fmt
    import uart_cmd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    output logic [8*DIGITS-1:0] o_ascii
);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign o_ascii[8*g +: 8] = nib_to_ascii(i_bcd[4*g +: 4]);
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_decoder
// Brief   : Matches "<letter><TERM>" against N_CMD codes, emits strobes and an
//           optional busy/done handshake, and formats a BCD value as ASCII.
//           Optional macro CMD_DROP_CNT_EN adds the drop_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int                 N_CMD       = 4,
    parameter logic [8*N_CMD-1:0] CMD_CODES   = 32'h61_6E_70_72,
    parameter logic [N_CMD-1:0]   HS_MASK     = 4'b1000,
    parameter logic [7:0]         TERM        = 8'h3B,
    parameter logic [31:0]        TIMEOUT_CYC = 32'd5_000_000,
    parameter int                 DIGITS      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_vld,
    input  logic [7:0]            rx_data,
    input  logic [N_CMD-1:0]      cmd_done,
    input  logic [4*DIGITS-1:0]   value_bcd,
    output logic [N_CMD-1:0]      cmd_strobe,
    output logic [N_CMD-1:0]      cmd_busy,
    output logic                  err_unknown,
    output logic [8*DIGITS-1:0]   value_ascii
`ifdef CMD_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam logic [31:0] c_TO_LAST = (TIMEOUT_CYC == 32'd0) ? 32'd0 : (TIMEOUT_CYC - 32'd1);

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_letter, w_letter_nxt;
    logic [31:0]        r_timer;
    logic [N_CMD-1:0]   r_strobe, w_strobe_nxt;
    logic [N_CMD-1:0]   r_busy, w_busy_nxt;
    logic               r_err, w_err_nxt;
    logic [N_CMD-1:0]   w_hit;
    logic [N_CMD-1:0]   w_sel;
    logic               w_is_term;
    logic               w_is_letter;
    logic               w_timeout;

    assign w_is_term   = rx_vld && (rx_data == TERM);
    assign w_is_letter = rx_vld && (rx_data != TERM);
    assign w_timeout   = (TIMEOUT_CYC != 32'd0) && (r_state == ARMED) && !rx_vld
                         && (r_timer >= c_TO_LAST);

    for (genvar i = 0; i < N_CMD; i++) begin : g_match
        if (i < MAX_CMD) begin : g_cmp
            assign w_hit[i] = (r_letter == CMD_CODES[8*i +: 8]);
        end else begin : g_none
            assign w_hit[i] = 1'b0;
        end
    end

    // Lowest matching command index wins; w_sel is one-hot or zero.
    always_comb begin
        w_sel = '0;
        for (int i = N_CMD - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_letter_nxt = r_letter;
        w_strobe_nxt = '0;
        w_busy_nxt   = r_busy;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_letter) begin
                    w_letter_nxt = rx_data;
                    w_state_nxt  = ARMED;
                end
            end
            ARMED: begin
                if (w_is_letter) begin
                    w_letter_nxt = rx_data;
                end else if (w_is_term) begin
                    if (|w_hit) begin
                        w_strobe_nxt = w_sel;
                        if (|(w_sel & HS_MASK)) begin
                            w_busy_nxt  = w_sel;
                            w_state_nxt = BUSY;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_timeout) begin
                    w_letter_nxt = 8'd0;
                    w_state_nxt  = IDLE;
                end
            end
            BUSY: begin
                // r_busy is one-hot on the active command, so it masks foreign done bits.
                if (|(cmd_done & r_busy)) begin
                    w_busy_nxt  = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_busy_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_letter <= 8'd0;
            r_strobe <= '0;
            r_busy   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_letter <= w_letter_nxt;
            r_strobe <= w_strobe_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_vld || (r_state != ARMED)) begin
            r_timer <= 32'd0;
        end else if (r_timer != 32'hFFFF_FFFF) begin
            r_timer <= r_timer + 32'd1;
        end
    end

`ifdef CMD_DROP_CNT_EN
    logic [7:0] r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 8'd0;
        end else if ((((r_state == BUSY) && rx_vld) || w_timeout) && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign drop_cnt = r_drop;
`endif

    assign cmd_strobe  = r_strobe;
    assign cmd_busy    = r_busy;
    assign err_unknown = r_err;

    bcd_ascii_fmt #(
        .DIGITS (DIGITS)
    ) u_fmt (
        .i_bcd   (value_bcd),
        .o_ascii (value_ascii)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_decoder
// Brief   : Self-checking bench with directed scenarios and randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

    localparam int          TO   = 100;
    localparam logic [7:0]  TRM  = 8'h3B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [3:0]  cmd_done = 4'd0;
    logic [11:0] value_bcd = 12'd0;
    logic [3:0]  cmd_strobe;
    logic [3:0]  cmd_busy;
    logic        err_unknown;
    logic [23:0] value_ascii;
`ifdef CMD_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: command table plus a mode (0 idle, 1 armed, 2 busy).
    logic [7:0] codes [4] = '{8'h72, 8'h70, 8'h6E, 8'h61};
    logic [3:0] hs = 4'b1000;
    int         m_mode, m_quiet, m_act, m_drop;
    logic [7:0] m_letter;
    logic [3:0] m_strobe, m_busy;
    logic       m_err;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYC(32'd100)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_vld      (rx_vld),
        .rx_data     (rx_data),
        .cmd_done    (cmd_done),
        .value_bcd   (value_bcd),
        .cmd_strobe  (cmd_strobe),
        .cmd_busy    (cmd_busy),
        .err_unknown (err_unknown),
        .value_ascii (value_ascii)
`ifdef CMD_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    task automatic model_reset();
        m_mode = 0; m_quiet = 0; m_act = 0; m_drop = 0;
        m_letter = 8'd0; m_strobe = 4'd0; m_busy = 4'd0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic [3:0] dn);
        int hit;
        hit = -1;
        m_strobe = 4'd0;
        m_err = 1'b0;
        case (m_mode)
            0: if (v && d != TRM) begin m_letter = d; m_mode = 1; m_quiet = 0; end
            1: begin
                if (v && d != TRM) begin
                    m_letter = d; m_quiet = 0;
                end else if (v) begin
                    for (int i = 3; i >= 0; i--) if (codes[i] == m_letter) hit = i;
                    if (hit < 0) begin
                        m_err = 1'b1; m_mode = 0;
                    end else begin
                        m_strobe[hit] = 1'b1;
                        if (hs[hit]) begin m_mode = 2; m_act = hit; end
                        else m_mode = 0;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet == TO) begin m_mode = 0; if (m_drop < 255) m_drop++; end
                end
            end
            default: begin
                if (v && m_drop < 255) m_drop++;
                if (dn[m_act]) m_mode = 0;
            end
        endcase
        m_busy = (m_mode == 2) ? 4'(1 << m_act) : 4'd0;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] dn);
        rx_vld = v; rx_data = d; cmd_done = dn;
        @(posedge clk);
        model_step(v, d, dn);
        #1;
        rx_vld = 1'b0; cmd_done = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (cmd_strobe !== 4'd0 || cmd_busy !== 4'd0 || err_unknown !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got strobe=%b busy=%b err=%b exp 0", cmd_strobe, cmd_busy, err_unknown);
        end
`ifdef CMD_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_drop got %0d exp 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_strobe_only();
        drive(1, "p", 0);
        drive(1, TRM, 0);
        n_checks++;
        if (cmd_strobe !== 4'b0010 || cmd_busy !== 4'd0) begin
            n_errors++;
            $display("FAIL strobe_p got strobe=%b busy=%b exp 0010/0000", cmd_strobe, cmd_busy);
        end
        drive(0, 0, 0);
        n_checks++;
        if (cmd_strobe !== 4'd0 || cmd_busy !== 4'd0) begin
            n_errors++;
            $display("FAIL strobe_p_width got strobe=%b busy=%b exp 0", cmd_strobe, cmd_busy);
        end
    endtask

    task automatic test_handshake();
        drive(1, "a", 0);
        drive(1, TRM, 0);
        n_checks++;
        if (cmd_strobe !== 4'b1000 || cmd_busy !== 4'b1000) begin
            n_errors++;
            $display("FAIL hs_rise got strobe=%b busy=%b exp 1000/1000", cmd_strobe, cmd_busy);
        end
        drive(1, "n", 0);
        drive(1, TRM, 4'b0111);
        n_checks++;
        if (cmd_strobe !== 4'd0 || cmd_busy !== 4'b1000) begin
            n_errors++;
            $display("FAIL hs_drop_in_busy got strobe=%b busy=%b exp 0000/1000", cmd_strobe, cmd_busy);
        end
        repeat (7) drive(0, 0, 0);
        drive(0, 0, 4'b1000);
        n_checks++;
        if (cmd_busy !== 4'd0) begin
            n_errors++;
            $display("FAIL hs_done got busy=%b exp 0000", cmd_busy);
        end
        // Done asserted alongside the terminator must not complete the new command.
        drive(1, "a", 0);
        drive(1, TRM, 4'b1000);
        drive(0, 0, 0);
        n_checks++;
        if (cmd_busy !== 4'b1000) begin
            n_errors++;
            $display("FAIL hs_early_done got busy=%b exp 1000", cmd_busy);
        end
        drive(0, 0, 4'b1000);
        n_checks++;
        if (cmd_busy !== 4'd0) begin
            n_errors++;
            $display("FAIL hs_done2 got busy=%b exp 0000", cmd_busy);
        end
    endtask

    task automatic test_unknown();
        drive(1, "x", 0);
        drive(1, TRM, 0);
        n_checks++;
        if (err_unknown !== 1'b1 || cmd_strobe !== 4'd0) begin
            n_errors++;
            $display("FAIL err_x got err=%b strobe=%b exp 1/0000", err_unknown, cmd_strobe);
        end
        drive(1, TRM, 0);
        n_checks++;
        if (err_unknown !== 1'b0 || cmd_strobe !== 4'd0) begin
            n_errors++;
            $display("FAIL lone_term got err=%b strobe=%b exp 0/0000", err_unknown, cmd_strobe);
        end
    endtask

    task automatic test_last_letter_and_timeout();
        drive(1, "n", 0);
        drive(1, "r", 0);
        drive(1, TRM, 0);
        n_checks++;
        if (cmd_strobe !== 4'b0001) begin
            n_errors++;
            $display("FAIL last_letter got strobe=%b exp 0001", cmd_strobe);
        end
        drive(1, "r", 0);
        repeat (TO - 1) drive(0, 0, 0);
        drive(1, TRM, 0);
        n_checks++;
        if (cmd_strobe !== 4'b0001) begin
            n_errors++;
            $display("FAIL timeout_edge got strobe=%b exp 0001", cmd_strobe);
        end
        drive(1, "r", 0);
        repeat (TO) drive(0, 0, 0);
        drive(1, TRM, 0);
        n_checks++;
        if (cmd_strobe !== 4'd0 || err_unknown !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout got strobe=%b err=%b exp 0000/0", cmd_strobe, err_unknown);
        end
`ifdef CMD_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'(m_drop)) begin
            n_errors++;
            $display("FAIL timeout_drop got %0d exp %0d", drop_cnt, m_drop);
        end
`endif
    endtask

    task automatic test_ascii();
        logic [23:0] exp;
        value_bcd = 12'h407;
        #1;
        n_checks++;
        if (value_ascii !== 24'h343037) begin
            n_errors++;
            $display("FAIL ascii_407 got %h exp 343037", value_ascii);
        end
        value_bcd = 12'h4A7;
        #1;
        n_checks++;
        if (value_ascii !== 24'h343F37) begin
            n_errors++;
            $display("FAIL ascii_4A7 got %h exp 343F37", value_ascii);
        end
        for (int k = 0; k < 20; k++) begin
            value_bcd = 12'($urandom);
            for (int d = 0; d < 3; d++) begin
                int nib;
                nib = (int'(value_bcd) >> (4 * d)) & 15;
                exp[8*d +: 8] = (nib < 10) ? 8'(48 + nib) : 8'd63;
            end
            #1;
            n_checks++;
            if (value_ascii !== exp) begin
                n_errors++;
                $display("FAIL ascii_rand bcd=%h got %h exp %h", value_bcd, value_ascii, exp);
            end
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive(1, "a", 0);
        drive(1, TRM, 0);
        repeat (3) drive(1, "p", 0);
`ifdef CMD_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL drop_cnt3 got %0d exp 3", drop_cnt);
        end
`endif
        n_checks++;
        if (cmd_busy !== 4'b1000) begin
            n_errors++;
            $display("FAIL busy_before_rst got %b exp 1000", cmd_busy);
        end
        do_reset();
        n_checks++;
        if (cmd_busy !== 4'd0 || cmd_strobe !== 4'd0) begin
            n_errors++;
            $display("FAIL rst_in_busy got busy=%b strobe=%b exp 0", cmd_busy, cmd_strobe);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [6] = '{8'h72, 8'h70, 8'h6E, 8'h61, 8'h78, 8'h3B};
        logic       v;
        logic [3:0] dn;
        for (int k = 0; k < 600; k++) begin
            if (k % 100 == 50) begin
                repeat ($urandom_range(TO - 3, TO + 3)) drive(0, 0, 0);
            end
            v  = ($urandom % 3) != 0;
            dn = (($urandom % 6) == 0) ? 4'($urandom) : 4'd0;
            drive(v, pool[$urandom % 6], dn);
            n_checks++;
            if (cmd_strobe !== m_strobe || cmd_busy !== m_busy || err_unknown !== m_err) begin
                n_errors++;
                $display("FAIL random k=%0d got s=%b b=%b e=%b exp s=%b b=%b e=%b",
                         k, cmd_strobe, cmd_busy, err_unknown, m_strobe, m_busy, m_err);
            end
`ifdef CMD_DROP_CNT_EN
            n_checks++;
            if (drop_cnt !== 8'(m_drop)) begin
                n_errors++;
                $display("FAIL random_drop k=%0d got %0d exp %0d", k, drop_cnt, m_drop);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_strobe_only();
        test_handshake();
        test_unknown();
        test_last_letter_and_timeout();
        test_ascii();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
